// File: rtl/nibble_seq_add.sv
// Wide add/subtract sequenced one nibble per clock through an external 4-bit ripple adder.
// Latency: start sampled at edge 0, RUN for NIBBLES cycles, done pulses in cycle NIBBLES+1.
// Backpressure: none; start is accepted only in IDLE and is ignored while busy is high.
module nibble_seq_add #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic                   cin_in,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
  output logic                   overflow,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;

  // Bit offset of the nibble currently being processed.
  logic [IW+1:0] nib_base;
  assign nib_base = {idx, 2'b00};

  // Status decoded straight from the state register so done is a clean one-cycle pulse.
  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);

  // Drive the external adder with the current nibble only while running; park it at zero otherwise.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[nib_base +: 4];
      add_b   = b_reg[nib_base +: 4];
      add_cin = carry;
    end
  end

  // Sequencer: latch operands, walk the nibbles LSB first, chain cout back into cin, flag completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1, so invert B and force the initial carry.
            a_reg     <= op_a;
            b_reg     <= sub ? ~op_b : op_b;
            carry     <= sub ? 1'b1 : cin_in;
            idx       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          result[nib_base +: 4] <= add_sum;
          carry                 <= add_cout;
          if (idx == LAST_IDX) begin
            // b_reg already holds the effective (possibly inverted) operand, so one rule covers add and sub.
            carry_out <= add_cout;
            overflow  <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[3] != a_reg[W-1]);
            state     <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_seq_add.sv
module tb_nibble_seq_add;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           sub;
  logic           cin_in;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           busy;
  logic           done;
  logic [W-1:0]   result;
  logic           carry_out;
  logic           overflow;
  logic [3:0]     add_a;
  logic [3:0]     add_b;
  logic           add_cin;
  logic [3:0]     add_sum;
  logic           add_cout;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   done_count = 0;

  always #5 clk = ~clk;

  // External 4-bit ripple adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  nibble_seq_add #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .cin_in    (cin_in),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic c);
    exp_t         e;
    logic [W-1:0] bb;
    logic         ci;
    logic [W:0]   full;
    bb   = s ? ~b : b;
    ci   = s ? 1'b1 : c;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
    e.r  = full[W-1:0];
    e.c  = full[W];
    e.v  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_count++;
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("result",    32'(result),    32'(e.r));
        check_eq("carry_out", 32'(carry_out), 32'(e.c));
        check_eq("overflow",  32'(overflow),  32'(e.v));
      end
    end
  end

  // Issue one operation, scramble inputs during RUN, and verify first-cycle cin and done latency.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c);
    int   lat;
    logic seen;
    @(negedge clk);
    start  = 1'b1;
    op_a   = a;
    op_b   = b;
    sub    = s;
    cin_in = c;
    sb.push_back(model(a, b, s, c));
    @(negedge clk);
    start  = 1'b0;
    op_a   = W'($urandom);
    op_b   = W'($urandom);
    sub    = 1'($urandom);
    cin_in = 1'($urandom);
    check_eq("first_cin",  32'(add_cin), s ? 32'd1 : 32'(c));
    check_eq("busy_run",   32'(busy), 32'd1);
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check_eq("done_latency", 32'(lat), 32'(NIBBLES + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc;
    rst    = 1'b1;
    start  = 1'b0;
    sub    = 1'b0;
    cin_in = 1'b0;
    op_a   = '0;
    op_b   = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy",      32'(busy),      32'd0);
    check_eq("rst_done",      32'(done),      32'd0);
    check_eq("rst_result",    32'(result),    32'd0);
    check_eq("rst_carry_out", 32'(carry_out), 32'd0);
    check_eq("rst_overflow",  32'(overflow),  32'd0);
    check_eq("rst_add_a",     32'(add_a),     32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_op(16'h0005, 16'h000A, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h0003, 16'h0005, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b0, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1);

    // Start requests while busy must be ignored.
    @(negedge clk);
    start = 1'b1; op_a = 16'h0102; op_b = 16'h0304; sub = 1'b0; cin_in = 1'b0;
    sb.push_back(model(16'h0102, 16'h0304, 1'b0, 1'b0));
    for (int cyc = 1; cyc <= NIBBLES + 1; cyc++) begin
      @(negedge clk);
      check_eq("busy_hold", 32'(busy), 32'd1);
      if (cyc >= 2 && cyc <= NIBBLES) begin
        start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; sub = 1'b1; cin_in = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("busy_after_done", 32'(busy), 32'd0);
    check_eq("no_requeue_done", 32'(done), 32'd0);

    // Reset in the second RUN cycle aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0; cin_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    dc  = done_count;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy",   32'(busy),   32'd0);
    check_eq("abort_result", 32'(result), 32'd0);
    check_eq("abort_done",   32'(done),   32'd0);
    repeat (NIBBLES + 3) @(negedge clk);
    check_eq("abort_no_pulse", 32'(done_count), 32'(dc));

    run_op(16'h00FF, 16'h0F01, 1'b0, 1'b0);

    // Random mix of adds and subtracts.
    for (int i = 0; i < 8; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nibble_seq_add.md
Name: nibble_seq_add

Overview:
- Sequencer that performs a 4*NIBBLES-bit add or subtract using one external 4-bit ripple adder (ports a, b, cin -> sum, cout), one nibble per clock, LSB nibble first.
- Sits directly upstream and downstream of the ripple adder: it drives the adder's operand and carry inputs and consumes sum and cout.
- It latches wide operands on a start request, feeds the adder each cycle and feeds cout back as the next cin.
- It assembles the result and reports carry and signed overflow with a one-cycle done pulse.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width is W = 4*NIBBLES; legal range 2..16.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = add, 1 = subtract (op_a - op_b); sampled with start.
- cin_in  in  1  carry-in for add mode; ignored when sub=1.
- op_a  in  W  operand A; sampled with start.
- op_b  in  W  operand B; sampled with start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result, carry_out and overflow are valid.
- result  out  W  sum or difference.
- carry_out  out  1  final adder cout; in sub mode 1 = no borrow.
- overflow  out  1  signed two's-complement overflow.
- add_a  out  4  to ripple adder a.
- add_b  out  4  to ripple adder b.
- add_cin  out  1  to ripple adder cin.
- add_sum  in  4  from ripple adder sum (combinational, same cycle).
- add_cout  in  1  from ripple adder cout.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, internal index 0, carry register 0, operand registers 0, result 0, carry_out 0, overflow 0, done 0, busy 0. Reset takes priority over everything, including mid-RUN or in DONE; an aborted operation produces no done pulse.
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch a_reg=op_a, b_reg = sub ? ~op_b : op_b, carry = sub ? 1 : cin_in. Also set index=0, clear result, carry_out and overflow, and go to RUN.
- IDLE, start=0: hold all outputs; result etc. keep the last completed values.
- RUN, combinational outputs: add_a = a_reg[4*index+3 : 4*index], add_b = b_reg nibble at the same index, add_cin = carry.
- RUN, each edge: result nibble[index] <= add_sum, carry <= add_cout, index <= index+1.
- RUN, last nibble (index == NIBBLES-1): also carry_out <= add_cout, overflow <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[3] != a_reg[W-1]), then go to DONE.
- DONE: done=1 for exactly this cycle, then unconditionally return to IDLE.
- Outside RUN: add_a, add_b and add_cin are driven to 0.
- Latency: start sampled at edge 0. RUN occupies cycles 1..NIBBLES. done is high during cycle NIBBLES+1 (cycle 5 for NIBBLES=4). Next start is accepted at the edge that ends the DONE cycle + 1, i.e. one clock in IDLE minimum.
- start while busy=1 is ignored; it is neither queued nor does it corrupt in-flight operands.
- Input changes on op_a, op_b, sub and cin_in during RUN have no effect.
- Wrap-around: result is modulo 2^W; carry_out is the only indication of unsigned overflow.
- Index width is ceil(log2(NIBBLES)); index never exceeds NIBBLES-1.

Test Plan:
- (NIBBLES=4, external ripple adder instantiated on the bench.)
- Add 0x0005 + 0x000A, cin_in=0 -> done in cycle 5 after start, result=0x000F, carry_out=0, overflow=0.
- Add 0xFFFF + 0x0001, cin_in=0 -> result=0x0000, carry_out=1, overflow=0 (carry ripples through all 4 nibbles).
- Sub 0x0003 - 0x0005 -> result=0xFFFE, carry_out=0 (borrow), overflow=0; add_cin=1 in the first RUN cycle.
- Add 0x7FFF + 0x0001 -> result=0x8000, carry_out=0, overflow=1. Also add 0x1234 + 0x4321 with cin_in=1 -> result=0x5556.
- Start again during RUN with different operands -> ignored; original result is reported and busy stays high until DONE ends.
- Assert rst in the 2nd RUN cycle -> next cycle is IDLE with result=0, busy=0, and done never pulses. A fresh start afterwards completes normally.
